// File: rtl/alu_pkg.sv
// Opcodes, FSM state encoding and opcode classification helpers for alu_multicycle.
// Divide support follows the ALU_DIV_EN build macro.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_MUL   = 4'b0110;
    localparam logic [3:0] ALU_XOR   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1000;
    localparam logic [3:0] ALU_SLT   = 4'b1001;
    localparam logic [3:0] ALU_SRA   = 4'b1010;
    localparam logic [3:0] ALU_MULHU = 4'b1011;
    localparam logic [3:0] ALU_DIVU  = 4'b1100;
    localparam logic [3:0] ALU_REMU  = 4'b1101;
    localparam logic [3:0] ALU_ADD   = 4'b1111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StDiv  = 2'b10,
        StDone = 2'b11
    } alu_state_e;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
`ifdef ALU_DIV_EN
        return (op == 4'b0010) || (op == 4'b1110);
`else
        return (op == 4'b0010) || (op == 4'b1110) || is_div_op(op);
`endif
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier and (with ALU_DIV_EN) restoring divider, one bit per cycle.
// res_lo/res_hi carry the post-iteration values so the caller can capture them on the done cycle.
module alu_iter_muldiv #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
`ifdef ALU_DIV_EN
    input  logic            is_div,
`endif
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done,
    output logic [XLEN-1:0] res_lo,
    output logic [XLEN-1:0] res_hi
);

    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic [XLEN-1:0] hi_d, lo_d;
    logic [SHW:0]    cnt_q;
    logic            busy_q;
    logic [XLEN:0]   sum;

`ifdef ALU_DIV_EN
    logic            div_q;
    logic [XLEN:0]   shifted;
`endif

    always_comb begin
        // Multiply step: conditional add of the multiplicand, then shift {carry, hi, lo} right.
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        hi_d = sum[XLEN:1];
        lo_d = {sum[0], lo_q[XLEN-1:1]};
`ifdef ALU_DIV_EN
        shifted = {hi_q, lo_q[XLEN-1]};
        if (div_q) begin
            if (shifted >= {1'b0, b_q}) begin
                hi_d = XLEN'(shifted - {1'b0, b_q});
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = shifted[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end
`endif
    end

    assign done   = busy_q && (cnt_q == '0);
    assign res_lo = lo_d;
    assign res_hi = hi_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
`ifdef ALU_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (start) begin
            hi_q   <= '0;
            cnt_q  <= (SHW+1)'(XLEN - 1);
            busy_q <= 1'b1;
`ifdef ALU_DIV_EN
            div_q  <= is_div;
            lo_q   <= is_div ? op_a : op_b;
            b_q    <= is_div ? op_b : op_a;
`else
            lo_q   <= op_b;
            b_q    <= op_a;
`endif
        end else if (busy_q) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - (SHW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle EX-stage ALU with valid/ready on both sides and registered result/zero flag.
// Build macro ALU_DIV_EN enables DIVU/REMU; without it they report illegal_op.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [3:0]      alu_control,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            zero_flag,
    output logic            illegal_op
);

    alu_state_e      state_q;
    logic [3:0]      op_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q, illegal_q;
    logic [XLEN-1:0] simple_res;
    logic [SHW-1:0]  shamt;
    logic            md_start, md_done;
    logic [XLEN-1:0] md_lo, md_hi, md_res;

    assign shamt = in2[SHW-1:0];

    always_comb begin
        simple_res = '0;
        case (alu_control)
            ALU_AND:  simple_res = in1 & in2;
            ALU_OR:   simple_res = in1 | in2;
            ALU_XOR:  simple_res = in1 ^ in2;
            ALU_ADD:  simple_res = in1 + in2;
            ALU_SUB:  simple_res = in1 - in2;
            ALU_SLTU: simple_res = {{(XLEN-1){1'b0}}, in1 < in2};
            ALU_SLT:  simple_res = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
            ALU_SLL:  simple_res = in1 << shamt;
            ALU_SRL:  simple_res = in1 >> shamt;
            ALU_SRA:  simple_res = XLEN'($signed(in1) >>> shamt);
            default:  simple_res = '0;
        endcase
    end

    assign md_start = in_valid && (state_q == StIdle) && !is_illegal(alu_control) &&
                      (is_mul_op(alu_control) || is_div_op(alu_control));
    // Low half holds product-low / quotient, high half holds product-high / remainder.
    assign md_res   = ((op_q == ALU_MUL) || (op_q == ALU_DIVU)) ? md_lo : md_hi;

    alu_iter_muldiv #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
`ifdef ALU_DIV_EN
        .is_div (is_div_op(alu_control)),
`endif
        .op_a   (in1),
        .op_b   (in2),
        .done   (md_done),
        .res_lo (md_lo),
        .res_hi (md_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= ALU_AND;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q <= alu_control;
                        if (is_illegal(alu_control)) begin
                            result_q  <= '0;
                            zero_q    <= 1'b1;
                            illegal_q <= 1'b1;
                            state_q   <= StDone;
                        end else if (is_mul_op(alu_control)) begin
                            state_q <= StMul;
                        end else if (is_div_op(alu_control)) begin
                            state_q <= StDiv;
                        end else begin
                            result_q  <= simple_res;
                            zero_q    <= (simple_res == '0);
                            illegal_q <= 1'b0;
                            state_q   <= StDone;
                        end
                    end
                end
                StMul, StDiv: begin
                    if (md_done) begin
                        result_q  <= md_res;
                        zero_q    <= (md_res == '0);
                        illegal_q <= 1'b0;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign alu_result = result_q;
    assign zero_flag  = zero_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised scoreboard bench for alu_multicycle against a plain-arithmetic reference model.
// Follows ALU_DIV_EN in the same way as the design build.
module tb_alu_multicycle;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in1 = '0;
    logic [XLEN-1:0] in2 = '0;
    logic [3:0]      alu_control = 4'b0000;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] alu_result;
    logic            zero_flag;
    logic            illegal_op;

    alu_multicycle #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in1         (in1),
        .in2         (in2),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .zero_flag   (zero_flag),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          acc;
        int          lat;
        logic [3:0]  op;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   force_low = 1'b0;
    bit   prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: mostly ready, sometimes stalls; force_low holds it off entirely.
    always @(posedge clk) begin
        #1;
        out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: what each opcode means, in plain arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output exp_t e);
        longint unsigned prod;
        prod  = longint'(a) * longint'(b);
        e.ill = 1'b0;
        e.lat = 1;
        e.op  = op;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0111: e.res = a ^ b;
            4'b1111: e.res = a + b;
            4'b0100: e.res = a - b;
            4'b1000: e.res = (a < b) ? 32'd1 : 32'd0;
            4'b1001: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: e.res = a << b[4:0];
            4'b0101: e.res = a >> b[4:0];
            4'b1010: e.res = 32'($signed(a) >>> b[4:0]);
            4'b0110: begin e.res = prod[31:0];  e.lat = XLEN + 1; end
            4'b1011: begin e.res = prod[63:32]; e.lat = XLEN + 1; end
`ifdef ALU_DIV_EN
            4'b1100: begin e.res = (b == 0) ? 32'hFFFF_FFFF : a / b; e.lat = XLEN + 1; end
            4'b1101: begin e.res = (b == 0) ? a : a % b;             e.lat = XLEN + 1; end
`endif
            default: begin e.res = '0; e.ill = 1'b1; end
        endcase
        e.zero = (e.res == 0);
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL in_ready_timeout at cycle %0d: got 0 expected 1", cyc);
            return;
        end
        in_valid    = 1'b1;
        alu_control = op;
        in1         = a;
        in2         = b;
        @(posedge clk);
        #1;
        model(op, a, b, e);
        e.acc = cyc;
        q.push_back(e);
        // Operands must be latched: scramble them immediately.
        in_valid    = 1'b0;
        alu_control = 4'($urandom);
        in1         = $urandom;
        in2         = $urandom;
    endtask

    // Monitor: every cycle the output is offered it must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output at cycle %0d: got valid result %0h expected none",
                         cyc, alu_result);
            end else begin
                e = q[0];
                if (!prev_valid) check($sformatf("latency op%b", e.op), cyc - e.acc + 1, e.lat);
                check($sformatf("result op%b", e.op), alu_result, e.res);
                check($sformatf("zero op%b", e.op), 32'(zero_flag), 32'(e.zero));
                check($sformatf("illegal op%b", e.op), 32'(illegal_op), 32'(e.ill));
                check("in_ready_while_valid", 32'(in_ready), 32'd0);
                if (out_ready) void'(q.pop_front());
            end
        end
        prev_valid = out_valid && !reset;
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout at cycle %0d: got %0d pending expected 0", cyc, q.size());
        end
    endtask

    initial begin
        logic [31:0] a, b;
        int          n;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_result", alu_result, 32'd0);
        check("reset_zero", 32'(zero_flag), 32'd0);
        check("reset_illegal", 32'(illegal_op), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        issue(4'b1111, 32'd5, 32'd7);
        issue(4'b0100, 32'd9, 32'd9);
        issue(4'b1001, 32'hFFFF_FFFF, 32'd1);
        issue(4'b1000, 32'hFFFF_FFFF, 32'd1);
        issue(4'b1010, 32'h8000_0000, 32'd4);
        issue(4'b0110, 32'hFFFF_FFFF, 32'd2);
        issue(4'b1011, 32'hFFFF_FFFF, 32'd2);
        issue(4'b1100, 32'd100, 32'd7);
        issue(4'b1101, 32'd100, 32'd7);
        issue(4'b1100, 32'd5, 32'd0);
        issue(4'b1101, 32'd5, 32'd0);
        issue(4'b0010, 32'd3, 32'd4);
        issue(4'b1110, 32'd3, 32'd4);
        wait_drain();

        // Consumer stalls for 10 cycles on a finished multiply.
        force_low = 1'b1;
        issue(4'b0110, 32'h1234_5678, 32'h9ABC_DEF1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        force_low = 1'b0;
        wait_drain();

        // Reset in the middle of a multiply discards it.
        issue(4'b0110, 32'hDEAD_BEEF, 32'h0000_0FFF);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_result", alu_result, 32'd0);
        reset = 1'b0;
        issue(4'b1111, 32'd40, 32'd2);
        issue(4'b0110, 32'd3, 32'd5);
        wait_drain();

        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            issue(4'($urandom), a, b);
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
